// File: rtl/completo_gpio_pkg.sv
// Shared constants for the completo_gpio AXI4-Lite GPIO peripheral.
package completo_gpio_pkg;

  localparam int unsigned GPIO_W  = 8;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SEL_BIT = 2;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_DIR  = 1'b1;

endpackage

// File: rtl/completo_gpio_pin_bank.sv
// GPIO pin bank: output/direction registers, input sampling and the effective pin view.
module completo_gpio_pin_bank
  import completo_gpio_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [GPIO_W-1:0] pindata,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [GPIO_W-1:0] wr_data,
  output logic [GPIO_W-1:0] Tx,
  output logic [GPIO_W-1:0] DSE,
  output logic [GPIO_W-1:0] Rx,
  output logic [GPIO_W-1:0] datanw
);

  logic [GPIO_W-1:0] pin_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Tx    <= '0;
      DSE   <= '0;
      Rx    <= '0;
      pin_q <= '0;
    end else begin
      pin_q <= pindata;
      Rx    <= pindata & ~DSE;
      if (wr_en && (wr_sel == REG_DATA)) Tx  <= wr_data;
      if (wr_en && (wr_sel == REG_DIR))  DSE <= wr_data;
    end
  end

  // Output pins reflect Tx, input pins reflect the sampled pad value.
  always_comb begin
    datanw = (Tx & DSE) | (pin_q & ~DSE);
  end

endmodule

// File: rtl/completo_gpio.sv
// AXI4-Lite slave front end for the GPIO pin bank: independent AW/W capture,
// write response, and single-beat registered reads.
module completo_gpio
  import completo_gpio_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] WAddress,
  input  logic              AWvalid,
  output logic              AWready,
  input  logic [DATA_W-1:0] Wdata,
  input  logic              Wvalid,
  output logic              Wready,
  output logic              Bvalid,
  input  logic              Bready,
  input  logic [ADDR_W-1:0] RAddress,
  input  logic              ARvalid,
  output logic              ARready,
  output logic [DATA_W-1:0] Rdata,
  output logic              Rvalid,
  input  logic              Rready,
  input  logic [GPIO_W-1:0] pindata,
  output logic [GPIO_W-1:0] Tx,
  output logic [GPIO_W-1:0] DSE,
  output logic [GPIO_W-1:0] Rx,
  output logic [GPIO_W-1:0] datanw
);

  logic              aw_cap, w_cap;
  logic              aw_sel_q;
  logic [GPIO_W-1:0] wdata_q;
  logic              bvalid_q, rvalid_q;
  logic [GPIO_W-1:0] rdata_q;
  logic              wr_en;

  // Only the select bit and the low data byte carry meaning.
  logic unused_bits;
  assign unused_bits = ^{WAddress, RAddress, Wdata[DATA_W-1:GPIO_W]};

  assign wr_en   = aw_cap & w_cap;
  assign AWready = ~aw_cap & ~bvalid_q;
  assign Wready  = ~w_cap & ~bvalid_q;
  assign ARready = ~rvalid_q;
  assign Bvalid  = bvalid_q;
  assign Rvalid  = rvalid_q;
  assign Rdata   = {{(DATA_W - GPIO_W){1'b0}}, rdata_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_cap   <= 1'b0;
      w_cap    <= 1'b0;
      aw_sel_q <= 1'b0;
      wdata_q  <= '0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (bvalid_q && Bready) bvalid_q <= 1'b0;

      if (wr_en) begin
        aw_cap   <= 1'b0;
        w_cap    <= 1'b0;
        bvalid_q <= 1'b1;
      end else begin
        if (AWvalid && AWready) begin
          aw_cap   <= 1'b1;
          aw_sel_q <= WAddress[SEL_BIT];
        end
        if (Wvalid && Wready) begin
          w_cap   <= 1'b1;
          wdata_q <= Wdata[GPIO_W-1:0];
        end
      end

      // Sampled before the pin bank updates, so a same-edge write is not visible.
      if (ARvalid && ARready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= (RAddress[SEL_BIT] == REG_DIR) ? DSE : datanw;
      end else if (rvalid_q && Rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  completo_gpio_pin_bank u_pin_bank (
    .clock   (clock),
    .reset   (reset),
    .pindata (pindata),
    .wr_en   (wr_en),
    .wr_sel  (aw_sel_q),
    .wr_data (wdata_q),
    .Tx      (Tx),
    .DSE     (DSE),
    .Rx      (Rx),
    .datanw  (datanw)
  );

endmodule

// File: tb/tb_completo_gpio.sv
// Directed bench for completo_gpio: hand-written handshake sequences plus a vector table.
module tb_completo_gpio;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] WAddress = '0;
  logic        AWvalid = 1'b0;
  logic        AWready;
  logic [31:0] Wdata = '0;
  logic        Wvalid = 1'b0;
  logic        Wready;
  logic        Bvalid;
  logic        Bready = 1'b0;
  logic [31:0] RAddress = '0;
  logic        ARvalid = 1'b0;
  logic        ARready;
  logic [31:0] Rdata;
  logic        Rvalid;
  logic        Rready = 1'b0;
  logic [7:0]  pindata = '0;
  logic [7:0]  Tx, DSE, Rx, datanw;

  int n_checks = 0;
  int n_fail   = 0;

  completo_gpio dut (
    .clock    (clock),
    .reset    (reset),
    .WAddress (WAddress),
    .AWvalid  (AWvalid),
    .AWready  (AWready),
    .Wdata    (Wdata),
    .Wvalid   (Wvalid),
    .Wready   (Wready),
    .Bvalid   (Bvalid),
    .Bready   (Bready),
    .RAddress (RAddress),
    .ARvalid  (ARvalid),
    .ARready  (ARready),
    .Rdata    (Rdata),
    .Rvalid   (Rvalid),
    .Rready   (Rready),
    .pindata  (pindata),
    .Tx       (Tx),
    .DSE      (DSE),
    .Rx       (Rx),
    .datanw   (datanw)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  pins;
    logic [7:0]  exp_tx;
    logic [7:0]  exp_dse;
    logic [7:0]  exp_rx;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    WAddress = a;
    Wdata    = d;
    AWvalid  = 1'b1;
    Wvalid   = 1'b1;
    tick();
    AWvalid = 1'b0;
    Wvalid  = 1'b0;
    n = 0;
    while (!Bvalid && n < 8) begin
      tick();
      n++;
    end
    check("wr_bvalid_rise", Bvalid, 1);
    Bready = 1'b1;
    tick();
    Bready = 1'b0;
    check("wr_bvalid_clear", Bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    RAddress = a;
    ARvalid  = 1'b1;
    tick();
    ARvalid = 1'b0;
    n = 0;
    while (!Rvalid && n < 8) begin
      tick();
      n++;
    end
    check("rd_rvalid_rise", Rvalid, 1);
    d = Rdata;
    Rready = 1'b1;
    tick();
    Rready = 1'b0;
    check("rd_rvalid_clear", Rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    // State entering the table: Tx=FF, DSE=00, pins=AA.
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_005A, 8'hAA, 8'h5A, 8'h00, 8'hAA, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0000_000F, 8'hAA, 8'h5A, 8'h0F, 8'hA0, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0,         8'h33, 8'h5A, 8'h0F, 8'h30, 32'h0000_003A};
    vecs[3] = '{1'b0, 32'hFFFF_FFFB, 32'h0,         8'hC3, 8'h5A, 8'h0F, 8'hC0, 32'h0000_00CA};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FF00, 8'hC3, 8'h5A, 8'h00, 8'hC3, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,         8'h81, 8'h5A, 8'h00, 8'h81, 32'h0000_0081};
    vecs[6] = '{1'b1, 32'h0000_0008, 32'h1234_56FF, 8'h81, 8'hFF, 8'h00, 8'h81, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0004, 32'h0,         8'h81, 8'hFF, 8'h00, 8'h81, 32'h0};

    // Reset state while reset is held.
    tick();
    tick();
    check("rst_awready", AWready, 1);
    check("rst_wready",  Wready,  1);
    check("rst_arready", ARready, 1);
    check("rst_bvalid",  Bvalid,  0);
    check("rst_rvalid",  Rvalid,  0);
    check("rst_rdata",   Rdata,   0);
    check("rst_tx",      Tx,      0);
    check("rst_dse",     DSE,     0);
    check("rst_rx",      Rx,      0);
    reset = 1'b0;
    tick();
    check("post_rst_awready", AWready, 1);

    // Write DATA: AWvalid held, Wvalid one-cycle pulse, Bready late.
    WAddress = 32'h0000_0EFA;
    Wdata    = 32'hABCD_EFFF;
    AWvalid  = 1'b1;
    Wvalid   = 1'b1;
    tick();
    Wvalid = 1'b0;
    check("wd_cap_bvalid",  Bvalid,  0);
    check("wd_cap_awready", AWready, 0);
    check("wd_cap_wready",  Wready,  0);
    tick();
    check("wd_bvalid",  Bvalid,  1);
    check("wd_tx",      Tx,      8'hFF);
    check("wd_awready", AWready, 0);
    check("wd_wready",  Wready,  0);
    tick();
    check("wd_bvalid_hold", Bvalid, 1);
    AWvalid = 1'b0;
    Bready  = 1'b1;
    tick();
    Bready = 1'b0;
    check("wd_bvalid_clr", Bvalid, 0);
    check("wd_awready_back", AWready, 1);
    check("wd_wready_back",  Wready,  1);

    // Write DIR: W arrives a cycle before AW.
    Wdata  = 32'hABCD_EFF1;
    Wvalid = 1'b1;
    tick();
    Wvalid = 1'b0;
    check("wdir_wready", Wready, 0);
    WAddress = 32'h0000_EFA6;
    AWvalid  = 1'b1;
    tick();
    AWvalid = 1'b0;
    check("wdir_bvalid_early", Bvalid, 0);
    tick();
    check("wdir_bvalid", Bvalid, 1);
    check("wdir_dse",    DSE,    8'hF1);
    check("wdir_tx",     Tx,     8'hFF);
    Bready = 1'b1;
    tick();
    Bready = 1'b0;
    check("wdir_bvalid_clr", Bvalid, 0);

    // Pin sampling.
    pindata = 8'hAA;
    #1;
    check("pin_datanw_pre", datanw, 8'hF1);
    tick();
    check("pin_rx",     Rx,     8'h0A);
    check("pin_datanw", datanw, 8'hFB);

    // Read DIR with data held until Rready.
    RAddress = 32'h0544_D884;
    ARvalid  = 1'b1;
    tick();
    ARvalid = 1'b0;
    check("rdir_rvalid",  Rvalid,  1);
    check("rdir_rdata",   Rdata,   32'h0000_00F1);
    check("rdir_arready", ARready, 0);
    tick();
    tick();
    check("rdir_rvalid_hold", Rvalid, 1);
    check("rdir_rdata_hold",  Rdata,  32'h0000_00F1);
    Rready = 1'b1;
    tick();
    Rready = 1'b0;
    check("rdir_rvalid_clr", Rvalid, 0);
    check("rdir_rdata_keep", Rdata,  32'h0000_00F1);

    do_read(32'h0000_0000, rd);
    check("rdata_val", rd, 32'h0000_00FB);

    // Read DIR on the same edge as a DIR write of 0x00.
    WAddress = 32'h0000_0004;
    Wdata    = 32'h0;
    AWvalid  = 1'b1;
    Wvalid   = 1'b1;
    tick();
    AWvalid  = 1'b0;
    Wvalid   = 1'b0;
    RAddress = 32'h0000_0004;
    ARvalid  = 1'b1;
    tick();
    ARvalid = 1'b0;
    check("rw_rvalid", Rvalid, 1);
    check("rw_rdata",  Rdata,  32'h0000_00F1);
    check("rw_dse",    DSE,    8'h00);
    check("rw_bvalid", Bvalid, 1);
    Bready = 1'b1;
    Rready = 1'b1;
    tick();
    Bready = 1'b0;
    Rready = 1'b0;
    check("rw_bvalid_clr", Bvalid, 0);
    check("rw_rvalid_clr", Rvalid, 0);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      pindata = vecs[i].pins;
      tick();
      tick();
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data);
      end else begin
        do_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      end
      tick();
      check($sformatf("vec%0d_tx", i),  Tx,  vecs[i].exp_tx);
      check($sformatf("vec%0d_dse", i), DSE, vecs[i].exp_dse);
      check($sformatf("vec%0d_rx", i),  Rx,  vecs[i].exp_rx);
    end

    // Reset while a write response is pending.
    WAddress = 32'h0;
    Wdata    = 32'h0000_003C;
    AWvalid  = 1'b1;
    Wvalid   = 1'b1;
    tick();
    AWvalid = 1'b0;
    Wvalid  = 1'b0;
    tick();
    check("rm_bvalid_pend", Bvalid, 1);
    reset = 1'b1;
    #1;
    check("rm_bvalid", Bvalid,  0);
    check("rm_tx",     Tx,      0);
    check("rm_dse",    DSE,     0);
    check("rm_rx",     Rx,      0);
    check("rm_awrdy",  AWready, 1);
    tick();
    reset = 1'b0;

    // Reset after AW captured alone: the address must be discarded.
    WAddress = 32'h0;
    AWvalid  = 1'b1;
    tick();
    AWvalid = 1'b0;
    check("rm_aw_cap", AWready, 0);
    reset = 1'b1;
    #1;
    check("rm_aw_drop", AWready, 1);
    tick();
    reset  = 1'b0;
    Wdata  = 32'h0000_0077;
    Wvalid = 1'b1;
    tick();
    Wvalid = 1'b0;
    tick();
    tick();
    check("rm_no_write_bvalid", Bvalid, 0);
    check("rm_no_write_tx",     Tx,     0);
    AWvalid = 1'b1;
    tick();
    AWvalid = 1'b0;
    tick();
    check("rm_fresh_bvalid", Bvalid, 1);
    check("rm_fresh_tx",     Tx,     8'h77);
    Bready = 1'b1;
    tick();
    Bready = 1'b0;
    check("rm_fresh_bclr", Bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/completo_gpio.md
Name: completo_gpio

Overview:
8-bit memory-mapped GPIO peripheral with a simplified AXI4-Lite slave interface. It has split write/read address channels, a write-data channel, a write-response handshake and a read-data channel. It holds an output-data register and a direction register. It samples the input pins and reports them back to the bus. It sits on the system AXI interconnect as a leaf slave.

Parameters:
GPIO_W, 8, number of pins; width of pindata, Tx, Rx, DSE and datanw.
ADDR_W, 32, width of WAddress and RAddress.
DATA_W, 32, width of Wdata and Rdata.
SEL_BIT, 2, address bit that selects the register.

Ports:
clock  in  1  single system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
WAddress  in  32  write address.
AWvalid  in  1  write address valid.
AWready  out  1  write address ready.
Wdata  in  32  write data.
Wvalid  in  1  write data valid.
Wready  out  1  write data ready.
Bvalid  out  1  write response valid.
Bready  in  1  write response accept.
RAddress  in  32  read address.
ARvalid  in  1  read address valid.
ARready  out  1  read address ready.
Rdata  out  32  read data.
Rvalid  out  1  read data valid.
Rready  in  1  read data accept.
pindata  in  8  pad input values.
Tx  out  8  output-data register.
DSE  out  8  direction register; 1 = pin driven by Tx, 0 = input.
Rx  out  8  registered input pins, masked to input-direction bits.
datanw  out  8  effective pin view.

Behaviour:
- Register map, decoded on address bit SEL_BIT; all other address bits are ignored:
  - SEL_BIT=0: DATA register. Write sets Tx=Wdata[7:0]. Read returns {24'b0, datanw}.
  - SEL_BIT=1: DIR register. Write sets DSE=Wdata[7:0]. Read returns {24'b0, DSE}.
  - Wdata[31:8] is ignored. No write strobes are used.
- Reset (asynchronous, active-high): Tx, DSE, Rx, pin_q, Rdata = 0; Bvalid = Rvalid = 0; capture flags cleared. AWready, Wready and ARready read 1 while reset is held and immediately after release.
- Reset mid-transaction aborts the transaction: captured address/data are discarded and a pending Bvalid/Rvalid is dropped.
- Pin sampling: pin_q <= pindata every cycle. Rx <= pindata & ~DSE, registered, 1-cycle latency. datanw = (Tx & DSE) | (pin_q & ~DSE), combinational.
- Write path (AW and W captured independently, in either order or simultaneously):
  - AWready = ~aw_cap & ~Bvalid. An AWvalid&AWready edge latches WAddress and sets aw_cap.
  - Wready = ~w_cap & ~Bvalid. A Wvalid&Wready edge latches Wdata and sets w_cap.
  - A one-cycle Wvalid pulse must be captured even if AWvalid arrives later.
  - On the first edge where aw_cap & w_cap: update the selected register, set Bvalid=1, clear both flags.
  - Bvalid holds until a Bvalid&Bready edge, then clears. No new AW/W is accepted while Bvalid=1.
- Read path:
  - ARready = ~Rvalid.
  - An ARvalid&ARready edge loads Rdata from the selected register and sets Rvalid=1 on that same edge, so data is visible the following cycle.
  - Rdata and Rvalid stay stable until a Rvalid&Rready edge, which clears Rvalid. Rdata keeps its last value.
- Read and write channels are independent. A read and a register write on the same edge: the read returns the pre-write value.
- Bready with no pending response, and Rready with Rvalid=0, are ignored.

Decomposition:
- Shared package holds:
  - GPIO_W, ADDR_W, DATA_W, SEL_BIT;
  - register select constants REG_DATA=0 and REG_DIR=1.
- One sub-module is natural: gpio_pin_bank, containing the Tx/DSE registers, pin_q/Rx sampling and the datanw mux. The top level holds the AXI capture/response logic.

Test Plan:
- Write DATA: WAddress=0xEFA, Wdata=0xABCDEFFF, AWvalid held, Wvalid pulsed for 1 cycle, Bready asserted later -> Tx=0xFF. Bvalid rises 1 cycle after both captures and clears on Bready. AWready and Wready are 0 while Bvalid is pending.
- Write DIR: WAddress=0xEFA6, Wdata=0xABCDEFF1, Wvalid asserted before AWvalid -> DSE=0xF1, Tx unchanged at 0xFF.
- Pins: with Tx=0xFF, DSE=0xF1, pindata=0xAA -> Rx=0x0A and datanw=0xFB one cycle after pindata is applied.
- Read DIR: RAddress=0x0544D884 (bit 2 set), ARvalid pulsed -> Rvalid=1 next cycle, Rdata=0x000000F1, held until Rready. ARready=0 while Rvalid=1.
- Read DATA: RAddress=0x0 -> Rdata=0x000000FB. Read on the same edge as a DIR write of 0x00 -> Rdata returns the old value 0x000000F1.
- Reset mid-op: assert reset while Bvalid=1 and after AW is captured without W -> Bvalid=0, Tx=DSE=Rx=0. The next write needs both fresh handshakes.
